mem_responder: RTL

Memory-side responder for the CPU's memory command interface. It accepts `MREAD`/`MWRITE` commands on `mem_cmd`/`mem_addr`/`write_data`, applies a fixed number of wait states, and services each command from a 256-word RAM or from memory-mapped switch/LED I/O. It returns `read_data` with a one-cycle `mem_ready` strobe. It sits between `cpu` and the board I/O in the top level and replaces the combinational RAM/tri-state glue.

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// CPU-to-memory command/response bundle: the CPU drives commands, the responder returns data and strobes.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [1:0]            mem_cmd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  mem_ready;
    logic                  bad_access;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready, bad_access
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready, bad_access
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: wait-stated access to a 256-word RAM plus switch/LED I/O,
// answering each command with a one-cycle mem_ready strobe.
module mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_responder_if.slave bus,
    input  logic [7:0] SW,
    output logic [7:0] LEDR
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LED_ADDR = ADDR_WIDTH'('h100);
    localparam logic [ADDR_WIDTH-1:0] SW_ADDR  = ADDR_WIDTH'('h140);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                r_state;
    logic [1:0]            r_cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_ready;
    logic                  r_bad;
    logic [7:0]            r_led;
    logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];

    logic                  w_cmd_valid;
    logic [1:0]            w_cmd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_is_ram;
    logic                  w_is_sw;
    logic                  w_is_led;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_enter_resp;

    // With zero wait states the response is formed on the sampling edge, so decode
    // looks at the live bus while idle and at the latched command otherwise.
    always_comb begin
        w_cmd_valid  = (bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE);
        w_cmd        = (r_state == S_IDLE) ? bus.mem_cmd  : r_cmd;
        w_addr       = (r_state == S_IDLE) ? bus.mem_addr : r_addr;
        w_is_ram     = ~w_addr[ADDR_WIDTH-1];
        w_is_sw      = (w_addr == SW_ADDR);
        w_is_led     = (w_addr == LED_ADDR);
        w_rd_ok      = w_is_ram || w_is_sw;
        w_wr_ok      = w_is_ram || w_is_led;
        w_rd_val     = w_is_ram ? r_ram[w_addr[RAM_AW-1:0]] : DATA_WIDTH'(SW);
        w_enter_resp = ((r_state == S_IDLE) && w_cmd_valid && (WS == 4'd0)) ||
                       ((r_state == S_BUSY) && (r_cnt <= 4'd1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= CMD_NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_read_data <= '0;
            r_ready     <= 1'b0;
            r_bad       <= 1'b0;
            r_led       <= '0;
        end else begin
            r_ready <= 1'b0;
            r_bad   <= 1'b0;
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                if (w_cmd == CMD_READ) begin
                    r_read_data <= w_rd_ok ? w_rd_val : '0;
                    r_bad       <= ~w_rd_ok;
                end else begin
                    r_bad <= ~w_wr_ok;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_valid) begin
                        r_cmd   <= bus.mem_cmd;
                        r_addr  <= bus.mem_addr;
                        r_wdata <= bus.write_data;
                        r_cnt   <= WS;
                        r_state <= (WS == 4'd0) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if ((r_cmd == CMD_WRITE) && w_is_led) r_led <= r_wdata[7:0];
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM keeps its contents across reset; a reset before RESP ends leaves it untouched.
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && (r_cmd == CMD_WRITE) && w_is_ram)
            r_ram[w_addr[RAM_AW-1:0]] <= r_wdata;
    end

    assign bus.read_data  = r_read_data;
    assign bus.mem_ready  = r_ready;
    assign bus.bad_access = r_bad;
    assign LEDR           = r_led;
endmodule
